// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared ALU control codes, width defaults and arbiter state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_CTRL_W = 4;

    localparam logic [3:0] c_ALU_ADD = 4'b0000;
    localparam logic [3:0] c_ALU_SUB = 4'b0001;
    localparam logic [3:0] c_ALU_AND = 4'b0010;
    localparam logic [3:0] c_ALU_OR  = 4'b0011;
    localparam logic [3:0] c_ALU_XOR = 4'b0100;
    localparam logic [3:0] c_ALU_SLL = 4'b0101;
    localparam logic [3:0] c_ALU_SRL = 4'b0110;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;
    localparam logic [3:0] c_ALU_BEQ = 4'b1000;
    localparam logic [3:0] c_ALU_BGE = 4'b1001;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way round-robin grant cell; one-hot grant, zero when disabled.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            unique case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                // Contention goes to the port that did not win last time.
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module : alu_arbiter
// Brief  : Round-robin sharing of one ALU between two requesters, with a
//          registered valid/ready response. Optional macro: ALU_ARB_PERF_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int CTRL_W = ALU_CTRL_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [1:0]        req_valid_i,
    output logic [1:0]        req_ready_o,
    input  logic [DATA_W-1:0] req0_data1_i,
    input  logic [DATA_W-1:0] req0_data2_i,
    input  logic [CTRL_W-1:0] req0_ctrl_i,
    input  logic [DATA_W-1:0] req1_data1_i,
    input  logic [DATA_W-1:0] req1_data2_i,
    input  logic [CTRL_W-1:0] req1_ctrl_i,
    output logic [DATA_W-1:0] alu_data1_o,
    output logic [DATA_W-1:0] alu_data2_o,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic              alu_branch_flag_i,
    input  logic              alu_zero_i,
    output logic [1:0]        resp_valid_o,
    input  logic [1:0]        resp_ready_i,
    output logic [DATA_W-1:0] resp_data_o,
    output logic              resp_branch_o,
`ifdef ALU_ARB_PERF_EN
    output logic [31:0]       perf_grant0_o,
    output logic [31:0]       perf_grant1_o,
    output logic [31:0]       perf_conflict_o,
    output logic [31:0]       perf_stall_o,
`endif
    output logic              resp_zero_o
);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic              r_owner;
    logic              r_last_grant;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_resp_branch;
    logic              r_resp_zero;

    logic [1:0]        w_grant;
    logic              w_owner_ready;
    logic              w_can_accept;
    logic              w_accept;
    logic              w_gidx;

    assign w_owner_ready = resp_ready_i[r_owner];
    assign w_can_accept  = (r_state == IDLE) | ((r_state == RESP) & w_owner_ready);

    rr_arb2 u_rr_arb2 (
        .req        (req_valid_i),
        .last_grant (r_last_grant),
        .enable     (w_can_accept),
        .grant      (w_grant)
    );

    // Grants are only issued to valid ports, so any grant is an accept.
    assign w_accept    = |w_grant;
    assign w_gidx      = w_grant[1];
    assign req_ready_o = w_grant;

    always_comb begin
        alu_data1_o = '0;
        alu_data2_o = '0;
        alu_ctrl_o  = '0;
        if (w_grant[0]) begin
            alu_data1_o = req0_data1_i;
            alu_data2_o = req0_data2_i;
            alu_ctrl_o  = req0_ctrl_i;
        end else if (w_grant[1]) begin
            alu_data1_o = req1_data1_i;
            alu_data2_o = req1_data2_i;
            alu_ctrl_o  = req1_ctrl_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = RESP;
        end else if ((r_state == RESP) && w_owner_ready) begin
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_owner       <= 1'b0;
            r_last_grant  <= 1'b1;
            r_resp_data   <= '0;
            r_resp_branch <= 1'b0;
            r_resp_zero   <= 1'b0;
        end else if (w_accept) begin
            r_owner       <= w_gidx;
            r_last_grant  <= w_gidx;
            r_resp_data   <= alu_data_i;
            r_resp_branch <= alu_branch_flag_i;
            r_resp_zero   <= alu_zero_i;
        end
    end

    // Valid is a pure decode of the registered state, so reset clears it at once.
    assign resp_valid_o  = (r_state == RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign resp_data_o   = r_resp_data;
    assign resp_branch_o = r_resp_branch;
    assign resp_zero_o   = r_resp_zero;

`ifdef ALU_ARB_PERF_EN
    logic [31:0] r_perf_grant0;
    logic [31:0] r_perf_grant1;
    logic [31:0] r_perf_conflict;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_perf_grant0   <= '0;
            r_perf_grant1   <= '0;
            r_perf_conflict <= '0;
            r_perf_stall    <= '0;
        end else begin
            if (w_grant[0]) r_perf_grant0 <= r_perf_grant0 + 32'd1;
            if (w_grant[1]) r_perf_grant1 <= r_perf_grant1 + 32'd1;
            if ((&req_valid_i) && w_can_accept) r_perf_conflict <= r_perf_conflict + 32'd1;
            if ((r_state == RESP) && !w_owner_ready) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_grant0_o   = r_perf_grant0;
    assign perf_grant1_o   = r_perf_grant1;
    assign perf_conflict_o = r_perf_conflict;
    assign perf_stall_o    = r_perf_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module : tb_alu_arbiter
// Brief  : Directed table-driven bench for alu_arbiter with a behavioural ALU.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    logic [31:0] req0_data1_i, req0_data2_i, req1_data1_i, req1_data2_i;
    logic [3:0]  req0_ctrl_i, req1_ctrl_i;
    logic [31:0] alu_data1_o, alu_data2_o;
    logic [3:0]  alu_ctrl_o;
    logic [31:0] alu_data_i;
    logic        alu_branch_flag_i, alu_zero_i;
    logic [1:0]  resp_valid_o, resp_ready_i;
    logic [31:0] resp_data_o;
    logic        resp_branch_o, resp_zero_o;
`ifdef ALU_ARB_PERF_EN
    logic [31:0] perf_grant0_o, perf_grant1_o, perf_conflict_o, perf_stall_o;
`endif

    alu_arbiter #(.DATA_W(32), .CTRL_W(4)) dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req0_data1_i      (req0_data1_i),
        .req0_data2_i      (req0_data2_i),
        .req0_ctrl_i       (req0_ctrl_i),
        .req1_data1_i      (req1_data1_i),
        .req1_data2_i      (req1_data2_i),
        .req1_ctrl_i       (req1_ctrl_i),
        .alu_data1_o       (alu_data1_o),
        .alu_data2_o       (alu_data2_o),
        .alu_ctrl_o        (alu_ctrl_o),
        .alu_data_i        (alu_data_i),
        .alu_branch_flag_i (alu_branch_flag_i),
        .alu_zero_i        (alu_zero_i),
        .resp_valid_o      (resp_valid_o),
        .resp_ready_i      (resp_ready_i),
        .resp_data_o       (resp_data_o),
        .resp_branch_o     (resp_branch_o),
`ifdef ALU_ARB_PERF_EN
        .perf_grant0_o     (perf_grant0_o),
        .perf_grant1_o     (perf_grant1_o),
        .perf_conflict_o   (perf_conflict_o),
        .perf_stall_o      (perf_stall_o),
`endif
        .resp_zero_o       (resp_zero_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural ALU driven by the arbiter's operand outputs.
    always_comb begin
        alu_data_i        = 32'd0;
        alu_branch_flag_i = 1'b0;
        case (alu_ctrl_o)
            c_ALU_ADD: alu_data_i = alu_data1_o + alu_data2_o;
            c_ALU_SUB: alu_data_i = alu_data1_o - alu_data2_o;
            c_ALU_AND: alu_data_i = alu_data1_o & alu_data2_o;
            c_ALU_OR:  alu_data_i = alu_data1_o | alu_data2_o;
            c_ALU_XOR: alu_data_i = alu_data1_o ^ alu_data2_o;
            c_ALU_SLL: alu_data_i = alu_data1_o << alu_data2_o[4:0];
            c_ALU_SRL: alu_data_i = alu_data1_o >> alu_data2_o[4:0];
            c_ALU_SLT: alu_data_i = {31'd0, $signed(alu_data1_o) < $signed(alu_data2_o)};
            c_ALU_BEQ: begin
                alu_data_i        = alu_data1_o - alu_data2_o;
                alu_branch_flag_i = (alu_data1_o == alu_data2_o);
            end
            c_ALU_BGE: begin
                alu_data_i        = alu_data1_o - alu_data2_o;
                alu_branch_flag_i = ($signed(alu_data1_o) >= $signed(alu_data2_o));
            end
            default: alu_data_i = 32'd0;
        endcase
        alu_zero_i = (alu_data_i == 32'd0);
    end

    typedef struct {
        logic        port;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [31:0] exp_data;
        logic        exp_br;
        logic        exp_z;
    } vec_t;

    vec_t vecs [11];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [1:0] onehot(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b0, 32'd5,        32'd3,        c_ALU_SUB, 32'd2,          1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'd7,        32'd8,        c_ALU_ADD, 32'd15,         1'b0, 1'b0};
        vecs[2]  = '{1'b0, 32'hF0,       32'h0F,       c_ALU_AND, 32'd0,          1'b0, 1'b1};
        vecs[3]  = '{1'b1, 32'hF0,       32'h0F,       c_ALU_OR,  32'hFF,         1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'hFF,       32'hFF,       c_ALU_XOR, 32'd0,          1'b0, 1'b1};
        vecs[5]  = '{1'b1, 32'd1,        32'd4,        c_ALU_SLL, 32'd16,         1'b0, 1'b0};
        vecs[6]  = '{1'b0, 32'h80,       32'd3,        c_ALU_SRL, 32'h10,         1'b0, 1'b0};
        vecs[7]  = '{1'b1, 32'hFFFFFFFF, 32'd1,        c_ALU_SLT, 32'd1,          1'b0, 1'b0};
        vecs[8]  = '{1'b0, 32'd9,        32'd9,        c_ALU_BEQ, 32'd0,          1'b1, 1'b1};
        vecs[9]  = '{1'b1, 32'd3,        32'd5,        c_ALU_BGE, 32'hFFFFFFFE,   1'b0, 1'b0};
        vecs[10] = '{1'b0, 32'd5,        32'd3,        c_ALU_BGE, 32'd2,          1'b1, 1'b0};

        rst_n_i      = 1'b0;
        req_valid_i  = 2'b00;
        resp_ready_i = 2'b00;
        req0_data1_i = '0; req0_data2_i = '0; req0_ctrl_i = '0;
        req1_data1_i = '0; req1_data2_i = '0; req1_ctrl_i = '0;
        #2;
        check("rst_resp_valid", {30'd0, resp_valid_o}, 32'd0);
        check("rst_resp_data", resp_data_o, 32'd0);
        check("rst_resp_flags", {30'd0, resp_branch_o, resp_zero_o}, 32'd0);
        check("rst_req_ready", {30'd0, req_ready_o}, 32'd0);
        check("idle_alu_drive", alu_data1_o | alu_data2_o | {28'd0, alu_ctrl_o}, 32'd0);
        tick();
        rst_n_i = 1'b1;
        tick();

        // Contention from reset with the owner always ready: strict 0,1,0,1 back-to-back.
        resp_ready_i = 2'b11;
        req_valid_i  = 2'b11;
        req0_data1_i = 32'd1;  req0_data2_i = 32'd2; req0_ctrl_i = c_ALU_ADD;
        req1_data1_i = 32'd10; req1_data2_i = 32'd4; req1_ctrl_i = c_ALU_SUB;
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr_ready_%0d", k), {30'd0, req_ready_o}, {30'd0, onehot(k[0])});
            tick();
            check($sformatf("rr_resp_valid_%0d", k), {30'd0, resp_valid_o}, {30'd0, onehot(k[0])});
            check($sformatf("rr_resp_data_%0d", k), resp_data_o, k[0] ? 32'd6 : 32'd3);
        end
        req_valid_i = 2'b00;
        #1;
        check("rr_drain_ready", {30'd0, req_ready_o}, 32'd0);
        tick();
        check("rr_drain_idle", {30'd0, resp_valid_o}, 32'd0);
        resp_ready_i = 2'b00;

        // Single-request vectors from IDLE, one per ALU op.
        for (int i = 0; i < 11; i++) begin
            req_valid_i = onehot(vecs[i].port);
            if (vecs[i].port) begin
                req1_data1_i = vecs[i].a; req1_data2_i = vecs[i].b; req1_ctrl_i = vecs[i].ctrl;
            end else begin
                req0_data1_i = vecs[i].a; req0_data2_i = vecs[i].b; req0_ctrl_i = vecs[i].ctrl;
            end
            #1;
            check($sformatf("v%0d_req_ready", i), {30'd0, req_ready_o}, {30'd0, onehot(vecs[i].port)});
            tick();
            req_valid_i = 2'b00;
            #1;
            check($sformatf("v%0d_resp_valid", i), {30'd0, resp_valid_o}, {30'd0, onehot(vecs[i].port)});
            check($sformatf("v%0d_resp_data", i), resp_data_o, vecs[i].exp_data);
            check($sformatf("v%0d_resp_flags", i), {30'd0, resp_branch_o, resp_zero_o},
                  {30'd0, vecs[i].exp_br, vecs[i].exp_z});
            resp_ready_i = onehot(vecs[i].port);
            tick();
            resp_ready_i = 2'b00;
            #1;
            check($sformatf("v%0d_release_idle", i), {30'd0, resp_valid_o}, 32'd0);
            check($sformatf("v%0d_data_hold", i), resp_data_o, vecs[i].exp_data);
        end

        // Backpressure: owner 0 stalls three cycles while both ports request.
        req_valid_i  = 2'b01;
        req0_data1_i = 32'd100; req0_data2_i = 32'd23; req0_ctrl_i = c_ALU_ADD;
        req1_data1_i = 32'd7;   req1_data2_i = 32'd8;  req1_ctrl_i = c_ALU_ADD;
        #1;
        check("bp_accept_ready", {30'd0, req_ready_o}, 32'd1);
        tick();
        req_valid_i = 2'b11;
        #1;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp_ready_%0d", c), {30'd0, req_ready_o}, 32'd0);
            check($sformatf("bp_valid_%0d", c), {30'd0, resp_valid_o}, 32'd1);
            check($sformatf("bp_data_%0d", c), resp_data_o, 32'd123);
            tick();
        end
        resp_ready_i = 2'b10;
        #1;
        check("nonowner_ready", {30'd0, req_ready_o}, 32'd0);
        tick();
        check("nonowner_valid", {30'd0, resp_valid_o}, 32'd1);
        check("nonowner_data", resp_data_o, 32'd123);
        resp_ready_i = 2'b01;
        #1;
        check("release_grant1", {30'd0, req_ready_o}, 32'd2);
        tick();
        resp_ready_i = 2'b00;
        req_valid_i  = 2'b00;
        #1;
        check("b2b_valid_switch", {30'd0, resp_valid_o}, 32'd2);
        check("b2b_data", resp_data_o, 32'd15);

        // Asynchronous reset while a response is held.
        #3;
        rst_n_i = 1'b0;
        #1;
        check("midrst_valid", {30'd0, resp_valid_o}, 32'd0);
        check("midrst_data", resp_data_o, 32'd0);
        tick();
        tick();
        rst_n_i     = 1'b1;
        req_valid_i = 2'b11;
        #1;
        check("midrst_first_grant", {30'd0, req_ready_o}, 32'd1);
        tick();
        req_valid_i = 2'b00;
        #1;
        check("midrst_resp_valid", {30'd0, resp_valid_o}, 32'd1);
        check("midrst_resp_data", resp_data_o, 32'd123);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
